// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: decodes the IR opcode and drives every datapath select/enable.
// Optional macro CTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_op output.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_RD    = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WR    = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] ADDI_EXEC = 4'd9;
  localparam logic [3:0] ADDI_WB   = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] TRAP      = 4'd12;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       is_store;
  logic       pc_write;
  logic       pc_write_cond;
  logic       op_valid;

  // The lw/sw choice is captured in DECODE so later opcode changes cannot redirect MEM_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE)
        is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    op_valid = 1'b1;
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_valid = 1'b1;
      default:                                  op_valid = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_R:         next_state = R_EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDI_EXEC;
          OP_J:         next_state = JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      next_state = TRAP;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  next_state = is_store ? MEM_WR : MEM_RD;
      MEM_RD:    next_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:    next_state = FETCH;
      MEM_WR:    next_state = mem_ready ? FETCH : MEM_WR;
      R_EXEC:    next_state = R_WB;
      R_WB:      next_state = FETCH;
      BRANCH:    next_state = FETCH;
      ADDI_EXEC: next_state = ADDI_WB;
      ADDI_WB:   next_state = FETCH;
      JUMP:      next_state = FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:      next_state = TRAP;
`endif
      default:   next_state = FETCH;
    endcase
  end

  // Reset gates every output so nothing strobes while the async reset is held.
  always_comb begin
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    instr_done    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
`ifndef CTRL_ILLEGAL_TRAP_EN
          instr_done = ~op_valid;
`endif
        end
        MEM_ADDR, ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
        end
        ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        TRAP: illegal_op = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // op_valid only matters for the NOP pulse; in trap builds it is intentionally left unobserved.
  assign pc_en = pc_write | (pc_write_cond & zero) | (1'b0 & op_valid);

endmodule
